// File: rtl/backoff_pkg.sv
// Shared definitions for the backoff scheduler: state encoding, LFSR polynomial and seed.
package backoff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IFS_WAIT = 2'd1,
        ST_BACKOFF  = 2'd2,
        ST_GRANT    = 2'd3
    } bo_state_e;

    // x^16 + x^14 + x^13 + x^11, right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        lfsr_step = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/backoff_ctrl_if.sv
// Channel-access handshake between the TX engine side (master) and the backoff scheduler (slave).
interface backoff_ctrl_if #(
    parameter int CW_EXP_MAX = 8,
    parameter int SLOT_W     = 10,
    parameter int IFS_W      = 14
);
    logic                  ch_idle;
    logic                  tx_req;
    logic                  tx_done;
    logic [3:0]            cw_exp;
    logic [SLOT_W-1:0]     slot_cycles;
    logic [IFS_W-1:0]      ifs_cycles;
    logic                  bo_ovr_en;
    logic [CW_EXP_MAX-1:0] bo_ovr_val;
    logic                  tx_grant;
    logic [CW_EXP_MAX-1:0] bo_cnt;
    logic [1:0]            state;

    modport master (
        output ch_idle, tx_req, tx_done, cw_exp, slot_cycles, ifs_cycles, bo_ovr_en, bo_ovr_val,
        input  tx_grant, bo_cnt, state
    );

    modport slave (
        input  ch_idle, tx_req, tx_done, cw_exp, slot_cycles, ifs_cycles, bo_ovr_en, bo_ovr_val,
        output tx_grant, bo_cnt, state
    );
endinterface

// File: rtl/backoff_lfsr.sv
// Free-running 16-bit Galois LFSR; only the low OUT_W bits are exported for the backoff draw.
module backoff_lfsr
    import backoff_pkg::*;
#(
    parameter logic [15:0] SEED  = LFSR_SEED_DEFAULT,
    parameter int          OUT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    output logic [OUT_W-1:0] lfsr
);
    logic [15:0] lfsr_r;

    // Advance one step every cycle, independent of scheduler state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_r <= SEED;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    assign lfsr = lfsr_r[OUT_W-1:0];

endmodule

// File: rtl/backoff_ctrl.sv
// DCF/EDCA channel-access scheduler: continuous-idle IFS, random slot backoff that freezes
// on a busy channel, then a registered grant held until the TX engine reports completion.
module backoff_ctrl
    import backoff_pkg::*;
#(
    parameter int          CW_EXP_MAX = 8,
    parameter int          SLOT_W     = 10,
    parameter int          IFS_W      = 14,
    parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
    input  logic          clk,
    input  logic          rstn,
    backoff_ctrl_if.slave bus
);
    bo_state_e             state_r;
    logic                  tx_grant_r;
    logic [CW_EXP_MAX-1:0] bo_cnt_r;
    logic [IFS_W-1:0]      ifs_cnt_r;
    logic [SLOT_W-1:0]     slot_cnt_r;

    logic [CW_EXP_MAX-1:0] lfsr_s;
    logic [IFS_W-1:0]      eff_ifs_s;
    logic [SLOT_W-1:0]     eff_slot_s;
    logic                  ifs_last_s;
    logic                  slot_last_s;
    logic [4:0]            cw_eff_s;
    logic [CW_EXP_MAX-1:0] mask_s;
    logic [CW_EXP_MAX-1:0] draw_s;

    backoff_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (CW_EXP_MAX)
    ) u_lfsr (
        .clk  (clk),
        .rstn (rstn),
        .lfsr (lfsr_s)
    );

    // Zero-length IFS/slot programming is treated as one cycle; >= guards a shrink mid-count
    always_comb begin
        if (bus.ifs_cycles == {IFS_W{1'b0}}) begin
            eff_ifs_s = IFS_W'(1);
        end else begin
            eff_ifs_s = bus.ifs_cycles;
        end
        if (bus.slot_cycles == {SLOT_W{1'b0}}) begin
            eff_slot_s = SLOT_W'(1);
        end else begin
            eff_slot_s = bus.slot_cycles;
        end
        ifs_last_s  = (ifs_cnt_r  >= (eff_ifs_s  - IFS_W'(1)));
        slot_last_s = (slot_cnt_r >= (eff_slot_s - SLOT_W'(1)));
    end

    // Backoff draw: exponent clamped to counter width, mask = 2^e - 1
    always_comb begin
        if ({1'b0, bus.cw_exp} > 5'(CW_EXP_MAX)) begin
            cw_eff_s = 5'(CW_EXP_MAX);
        end else begin
            cw_eff_s = {1'b0, bus.cw_exp};
        end
        mask_s = ~({CW_EXP_MAX{1'b1}} << cw_eff_s);
        if (bus.bo_ovr_en) begin
            draw_s = bus.bo_ovr_val;
        end else begin
            draw_s = lfsr_s & mask_s;
        end
    end

    // Scheduler FSM with IFS/slot counters and registered grant/backoff outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            tx_grant_r <= 1'b0;
            bo_cnt_r   <= {CW_EXP_MAX{1'b0}};
            ifs_cnt_r  <= {IFS_W{1'b0}};
            slot_cnt_r <= {SLOT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.tx_req) begin
                        bo_cnt_r   <= draw_s;
                        ifs_cnt_r  <= {IFS_W{1'b0}};
                        slot_cnt_r <= {SLOT_W{1'b0}};
                        state_r    <= ST_IFS_WAIT;
                    end
                end
                ST_IFS_WAIT: begin
                    if (!bus.tx_req) begin
                        bo_cnt_r <= {CW_EXP_MAX{1'b0}};
                        state_r  <= ST_IDLE;
                    end else if (!bus.ch_idle) begin
                        ifs_cnt_r <= {IFS_W{1'b0}};
                    end else if (ifs_last_s) begin
                        ifs_cnt_r  <= {IFS_W{1'b0}};
                        slot_cnt_r <= {SLOT_W{1'b0}};
                        if (bo_cnt_r == {CW_EXP_MAX{1'b0}}) begin
                            state_r    <= ST_GRANT;
                            tx_grant_r <= 1'b1;
                        end else begin
                            state_r <= ST_BACKOFF;
                        end
                    end else begin
                        ifs_cnt_r <= ifs_cnt_r + IFS_W'(1);
                    end
                end
                ST_BACKOFF: begin
                    if (!bus.tx_req) begin
                        bo_cnt_r <= {CW_EXP_MAX{1'b0}};
                        state_r  <= ST_IDLE;
                    end else if (!bus.ch_idle) begin
                        // Busy discards the partial slot; a full IFS must elapse again
                        ifs_cnt_r  <= {IFS_W{1'b0}};
                        slot_cnt_r <= {SLOT_W{1'b0}};
                        state_r    <= ST_IFS_WAIT;
                    end else if (slot_last_s) begin
                        slot_cnt_r <= {SLOT_W{1'b0}};
                        bo_cnt_r   <= bo_cnt_r - CW_EXP_MAX'(1);
                        if (bo_cnt_r == CW_EXP_MAX'(1)) begin
                            state_r    <= ST_GRANT;
                            tx_grant_r <= 1'b1;
                        end
                    end else begin
                        slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
                    end
                end
                ST_GRANT: begin
                    if (bus.tx_done) begin
                        state_r    <= ST_IDLE;
                        tx_grant_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    tx_grant_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_grant = tx_grant_r;
    assign bus.bo_cnt   = bo_cnt_r;
    assign bus.state    = state_r;

endmodule
